multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Next-generation control unit for the simple processor: replaces single-cycle opcode decode with a multicycle FSM sequencing IFETCH/DECODE/EXEC/MEM/WB.
- Supports variable-latency instruction and data memories through req/ready handshakes, with a watchdog timeout.
- Maintains a retired-instruction counter.
- Sits between the instruction register/ALU flags and the datapath enables: PC, IR, register file, ALU, data memory.

Parameters:
OPCODE_W, 5, opcode field width
ALUOP_W, 5, R-type ALU op field width
TIMEOUT, 16, max cycles waiting for a ready before bus error (>=2)
CNT_W, 32, retired-instruction counter width

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  IR opcode field, stable from DECODE onward
alu_op  in  ALUOP_W  IR ALU op field
alu_ne  in  1  ALU not-equal flag (EXEC)
alu_lt  in  1  ALU less-than flag (EXEC)
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable (with dmem_req)
ir_we  out  1  latch instruction register
pc_we  out  1  PC write enable
pc_sel  out  2  0 PC+1, 1 branch target, 2 jump target, 3 register (jr)
rf_we  out  1  register file write enable
rf_wsel  out  2  0 ALU result, 1 memory data, 2 PC+1 (jal)
rd_r31  out  1  force destination register to r31
alub_imm  out  1  ALU B operand = sign-extended immediate
aluop_ctrl  out  ALUOP_W  ALU operation
rtar_ctrl  out  1  second read port uses rd field (sw, bne, blt)
illegal_op  out  1  one-cycle pulse: unsupported opcode
bus_error  out  1  sticky: memory timeout
instr_cnt  out  CNT_W  retired instructions
state  out  3  FSM state, for debug

Behaviour:
- Opcodes: R=0, j=1, bne=2, jal=3, jr=4, addi=5, blt=6, sw=7, lw=8. Any other opcode is illegal.
- States: IDLE=0, IFETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset (async, reset_n low):
  - State goes to IDLE; wait counter, latched instruction class, bus_error and instr_cnt clear to 0.
  - All outputs are 0 while reset_n is low and while in IDLE.
  - IDLE moves to IFETCH unconditionally on the next clock.
  - Reset mid-operation aborts the instruction: no further pc_we, rf_we or dmem_we.
- Output timing: all outputs are Moore-decoded from state plus the class latched in DECODE. The exceptions are the ready/flag-qualified enables below, which are combinational in-cycle.
- IFETCH:
  - imem_req=1.
  - When imem_ready=1: ir_we=1, pc_we=1, pc_sel=0, go to DECODE.
  - Otherwise stay.
- DECODE (1 cycle):
  - Latch the opcode class and alu_op.
  - j: pc_we=1, pc_sel=2 -> IFETCH, retire.
  - jal: pc_we=1, pc_sel=2, rf_we=1, rf_wsel=2, rd_r31=1 -> IFETCH, retire.
  - jr: pc_we=1, pc_sel=3 -> IFETCH, retire.
  - R, addi, lw, sw, bne, blt: go to EXEC.
  - Illegal: illegal_op=1 -> IFETCH, no retire.
- EXEC:
  - alub_imm=1 for addi/lw/sw.
  - aluop_ctrl = latched alu_op for R-type; 0 (add) for addi/lw/sw; 1 (sub) for bne/blt.
  - rtar_ctrl=1 for sw/bne/blt.
  - bne: pc_we=alu_ne, pc_sel=1 -> IFETCH, retire.
  - blt: pc_we=alu_lt, pc_sel=1 -> IFETCH, retire.
  - lw/sw: go to MEM.
  - R/addi: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for sw; alub_imm=1 and aluop_ctrl=0 held so the address stays stable.
  - On dmem_ready: sw -> IFETCH (retire); lw -> WB.
- WB:
  - rf_we=1; rf_wsel=1 for lw, 0 otherwise; ALU controls held as in EXEC.
  - Go to IFETCH, retire.
- Retire: instr_cnt increments by 1 on the transition. It wraps modulo 2^CNT_W.
- Watchdog:
  - The counter clears on entry to IFETCH/MEM and increments each waiting cycle in those states.
  - If it reaches TIMEOUT-1 with ready still 0: set bus_error=1 (sticky) and go to HALT.
  - A ready arriving in the same cycle as the timeout wins: normal transition, no error.
  - HALT: all outputs 0 except bus_error and instr_cnt. Exit only by reset.
- Flags alu_ne/alu_lt are sampled only in EXEC. Ready inputs are ignored outside their own state.

Decomposition:
- Shared package: opcode constants, state encoding, pc_sel/rf_wsel encodings, ALU add/sub codes.
- One sub-module: mc_wait_timer (clear/enable/expired, TIMEOUT parameter), reused for both handshakes.

Test Plan:
- Reset then add (opcode 0, alu_op 0), imem_ready=1, with zero wait: IDLE->IFETCH->DECODE->EXEC->WB; rf_we=1 only in WB, rf_wsel=0; instr_cnt=1 after 5 cycles.
- lw (opcode 8) with dmem_ready delayed 3 cycles: dmem_req held 4 cycles, dmem_we=0; WB then has rf_wsel=1; bus_error=0.
- bne (opcode 2) run twice, alu_ne=1 then 0: pc_we=1 with pc_sel=1 in the first EXEC, pc_we=0 in the second; instr_cnt advances by 2.
- jal (opcode 3): in DECODE pc_sel=2, rf_we=1, rf_wsel=2, rd_r31=1; the next state is IFETCH.
- Opcode 9: illegal_op pulses for exactly 1 cycle, instr_cnt unchanged, and the FSM is back in IFETCH.
- imem_ready held 0 with TIMEOUT=16: bus_error=1 after 16 IFETCH cycles, state=HALT. Asserting reset_n low mid-HALT clears bus_error and returns the FSM to IDLE.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// instruction classes, datapath mux selects and ALU operation codes.
package multicycle_control_pkg;

   localparam int OP_R    = 0;
   localparam int OP_J    = 1;
   localparam int OP_BNE  = 2;
   localparam int OP_JAL  = 3;
   localparam int OP_JR   = 4;
   localparam int OP_ADDI = 5;
   localparam int OP_BLT  = 6;
   localparam int OP_SW   = 7;
   localparam int OP_LW   = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_IFETCH = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      CLS_R, CLS_J, CLS_BNE, CLS_JAL, CLS_JR,
      CLS_ADDI, CLS_BLT, CLS_SW, CLS_LW, CLS_ILL
   } cls_t;

   localparam logic [1:0] PC_INC  = 2'd0;
   localparam logic [1:0] PC_BR   = 2'd1;
   localparam logic [1:0] PC_JUMP = 2'd2;
   localparam logic [1:0] PC_REG  = 2'd3;

   localparam logic [1:0] WSEL_ALU = 2'd0;
   localparam logic [1:0] WSEL_MEM = 2'd1;
   localparam logic [1:0] WSEL_PC1 = 2'd2;

   localparam int ALU_ADD = 0;
   localparam int ALU_SUB = 1;

   function automatic cls_t op_class(input logic [31:0] op);
      case (op)
         OP_R:    return CLS_R;
         OP_J:    return CLS_J;
         OP_BNE:  return CLS_BNE;
         OP_JAL:  return CLS_JAL;
         OP_JR:   return CLS_JR;
         OP_ADDI: return CLS_ADDI;
         OP_BLT:  return CLS_BLT;
         OP_SW:   return CLS_SW;
         OP_LW:   return CLS_LW;
         default: return CLS_ILL;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Handshake watchdog: counts waiting cycles and flags expiry at TIMEOUT-1.
module mc_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT);

   logic [W-1:0] count;

   assign expired = (count == W'(TIMEOUT - 1));

   // Holds at the terminal value; the FSM leaves the waiting state on expiry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM sequencing fetch/decode/execute/memory/writeback
// with ready handshakes, watchdog bus error and retired-instruction count.
//
//  state  | meaning
//  IDLE   | post-reset, all outputs low, go to IFETCH
//  IFETCH | request instruction, latch IR and PC+1 on imem_ready
//  DECODE | latch class/alu_op, finish jumps, flag illegal opcodes
//  EXEC   | drive ALU, resolve branches
//  MEM    | data memory access, wait for dmem_ready
//  WB     | register file write
//  HALT   | bus error, stuck until reset
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int OPCODE_W = 5,
   parameter int ALUOP_W  = 5,
   parameter int TIMEOUT  = 16,
   parameter int CNT_W    = 32
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [ALUOP_W-1:0]  alu_op,
   input  logic                alu_ne,
   input  logic                alu_lt,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   output logic                imem_req,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic                ir_we,
   output logic                pc_we,
   output logic [1:0]          pc_sel,
   output logic                rf_we,
   output logic [1:0]          rf_wsel,
   output logic                rd_r31,
   output logic                alub_imm,
   output logic [ALUOP_W-1:0]  aluop_ctrl,
   output logic                rtar_ctrl,
   output logic                illegal_op,
   output logic                bus_error,
   output logic [CNT_W-1:0]    instr_cnt,
   output logic [2:0]          state
);

   state_t             state_q, state_d;
   cls_t               cls_q;
   cls_t               dec_cls;
   logic [ALUOP_W-1:0] aluop_q;
   logic               retire, set_err;
   logic               imem_exp, dmem_exp;
   logic               ex_imm, ex_rtar;
   logic [ALUOP_W-1:0] ex_aluop;

   assign dec_cls = op_class(32'(opcode));
   assign state   = state_q;

   mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_imem_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   ((state_q != S_IFETCH) || imem_ready),
      .enable  ((state_q == S_IFETCH) && !imem_ready),
      .expired (imem_exp)
   );

   mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_dmem_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   ((state_q != S_MEM) || dmem_ready),
      .enable  ((state_q == S_MEM) && !dmem_ready),
      .expired (dmem_exp)
   );

   // ALU controls as a function of the latched class, shared by EXEC and WB.
   always_comb begin
      ex_imm   = 1'b0;
      ex_rtar  = 1'b0;
      ex_aluop = '0;
      case (cls_q)
         CLS_R:    ex_aluop = aluop_q;
         CLS_ADDI, CLS_LW: begin
            ex_imm   = 1'b1;
            ex_aluop = ALUOP_W'(ALU_ADD);
         end
         CLS_SW: begin
            ex_imm   = 1'b1;
            ex_rtar  = 1'b1;
            ex_aluop = ALUOP_W'(ALU_ADD);
         end
         CLS_BNE, CLS_BLT: begin
            ex_rtar  = 1'b1;
            ex_aluop = ALUOP_W'(ALU_SUB);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = PC_INC;
      rf_we      = 1'b0;
      rf_wsel    = WSEL_ALU;
      rd_r31     = 1'b0;
      alub_imm   = 1'b0;
      aluop_ctrl = '0;
      rtar_ctrl  = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;
      set_err    = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_IFETCH;
         S_IFETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end else if (imem_exp) begin
               set_err = 1'b1;
               state_d = S_HALT;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
            case (dec_cls)
               CLS_J, CLS_JAL: begin
                  pc_we   = 1'b1;
                  pc_sel  = PC_JUMP;
                  retire  = 1'b1;
                  state_d = S_IFETCH;
                  if (dec_cls == CLS_JAL) begin
                     rf_we   = 1'b1;
                     rf_wsel = WSEL_PC1;
                     rd_r31  = 1'b1;
                  end
               end
               CLS_JR: begin
                  pc_we   = 1'b1;
                  pc_sel  = PC_REG;
                  retire  = 1'b1;
                  state_d = S_IFETCH;
               end
               CLS_ILL: begin
                  illegal_op = 1'b1;
                  state_d    = S_IFETCH;
               end
               default: ;
            endcase
         end
         S_EXEC: begin
            alub_imm   = ex_imm;
            aluop_ctrl = ex_aluop;
            rtar_ctrl  = ex_rtar;
            case (cls_q)
               CLS_BNE, CLS_BLT: begin
                  pc_we   = (cls_q == CLS_BNE) ? alu_ne : alu_lt;
                  pc_sel  = PC_BR;
                  retire  = 1'b1;
                  state_d = S_IFETCH;
               end
               CLS_LW, CLS_SW: state_d = S_MEM;
               default:        state_d = S_WB;
            endcase
         end
         S_MEM: begin
            dmem_req   = 1'b1;
            dmem_we    = (cls_q == CLS_SW);
            alub_imm   = 1'b1;
            aluop_ctrl = ALUOP_W'(ALU_ADD);
            if (dmem_ready) begin
               if (cls_q == CLS_SW) begin
                  retire  = 1'b1;
                  state_d = S_IFETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (dmem_exp) begin
               set_err = 1'b1;
               state_d = S_HALT;
            end
         end
         S_WB: begin
            rf_we      = 1'b1;
            rf_wsel    = (cls_q == CLS_LW) ? WSEL_MEM : WSEL_ALU;
            alub_imm   = ex_imm;
            aluop_ctrl = ex_aluop;
            rtar_ctrl  = ex_rtar;
            retire     = 1'b1;
            state_d    = S_IFETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cls_q     <= CLS_R;
         aluop_q   <= '0;
         bus_error <= 1'b0;
         instr_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            cls_q   <= dec_cls;
            aluop_q <= alu_op;
         end
         if (set_err) bus_error <= 1'b1;
         if (retire)  instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expectations are queued
// with the stimulus and checked by a monitor half a cycle later.
module tb_multicycle_control;

   localparam logic [2:0] IDLE = 3'd0, IF = 3'd1, DEC = 3'd2, EXE = 3'd3,
                          MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

   typedef struct packed {
      logic       imem_req;
      logic       dmem_req;
      logic       dmem_we;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_sel;
      logic       rf_we;
      logic [1:0] rf_wsel;
      logic       rd_r31;
      logic       alub_imm;
      logic [4:0] aluop;
      logic       rtar;
      logic       illegal;
      logic       bus_error;
   } ctl_t;

   typedef struct {
      string       tag;
      logic [2:0]  st;
      ctl_t        ctl;
      logic [31:0] cnt;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  opcode = '0;
   logic [4:0]  alu_op = '0;
   logic        alu_ne = 1'b0, alu_lt = 1'b0;
   logic        imem_ready = 1'b0, dmem_ready = 1'b0;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, rd_r31;
   logic        alub_imm, rtar_ctrl, illegal_op, bus_error;
   logic [1:0]  pc_sel, rf_wsel;
   logic [4:0]  aluop_ctrl;
   logic [31:0] instr_cnt;
   logic [2:0]  state;
   ctl_t        obs_ctl;

   exp_t        sb[$];
   logic [31:0] exp_cnt = '0;
   int          n_asserts = 0;
   int          n_fail = 0;

   always #5 clock = ~clock;

   multicycle_control dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode), .alu_op(alu_op),
      .alu_ne(alu_ne), .alu_lt(alu_lt), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .rf_we(rf_we), .rf_wsel(rf_wsel), .rd_r31(rd_r31), .alub_imm(alub_imm),
      .aluop_ctrl(aluop_ctrl), .rtar_ctrl(rtar_ctrl), .illegal_op(illegal_op),
      .bus_error(bus_error), .instr_cnt(instr_cnt), .state(state)
   );

   assign obs_ctl = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
                     rf_wsel, rd_r31, alub_imm, aluop_ctrl, rtar_ctrl,
                     illegal_op, bus_error};

   always @(negedge clock) begin
      exp_t e;
      #2;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_asserts++;
         assert (state === e.st) else begin
            n_fail++;
            $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
         end
         n_asserts++;
         assert (obs_ctl === e.ctl) else begin
            n_fail++;
            $error("FAIL %s ctl: got %h expected %h", e.tag, obs_ctl, e.ctl);
         end
         n_asserts++;
         assert (instr_cnt === e.cnt) else begin
            n_fail++;
            $error("FAIL %s instr_cnt: got %0d expected %0d", e.tag, instr_cnt, e.cnt);
         end
      end
   end

   task automatic step(input string tag, input logic [2:0] st, input ctl_t c);
      exp_t e;
      e.tag = tag;
      e.st  = st;
      e.ctl = c;
      e.cnt = exp_cnt;
      sb.push_back(e);
      @(negedge clock);
   endtask

   function automatic ctl_t c_if(input logic rdy);
      ctl_t c = '0;
      c.imem_req = 1'b1;
      c.ir_we    = rdy;
      c.pc_we    = rdy;
      return c;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      ctl_t c;
      @(negedge clock);
      step("reset", IDLE, '0);
      reset_n = 1'b1;
      step("idle", IDLE, '0);

      // add, zero wait
      opcode = 5'd0; alu_op = 5'd0; imem_ready = 1'b1;
      step("add_if", IF, c_if(1'b1));
      step("add_dec", DEC, '0);
      step("add_exec", EXE, '0);
      c = '0; c.rf_we = 1'b1;
      step("add_wb", WB, c);
      exp_cnt++;

      // R-type with a non-add op: alu_op must be the value latched in DECODE
      step("r_if", IF, c_if(1'b1));
      alu_op = 5'h0B;
      step("r_dec", DEC, '0);
      alu_op = 5'h1F;
      c = '0; c.aluop = 5'h0B;
      step("r_exec", EXE, c);
      c.rf_we = 1'b1;
      step("r_wb", WB, c);
      exp_cnt++;

      // lw with dmem_ready delayed 3 cycles
      opcode = 5'd8;
      step("lw_if", IF, c_if(1'b1));
      imem_ready = 1'b0;
      dmem_ready = 1'b1;
      step("lw_dec", DEC, '0);
      dmem_ready = 1'b0;
      c = '0; c.alub_imm = 1'b1;
      step("lw_exec", EXE, c);
      c.dmem_req = 1'b1;
      for (int i = 0; i < 3; i++) step("lw_mem_wait", MEM, c);
      dmem_ready = 1'b1;
      step("lw_mem_done", MEM, c);
      dmem_ready = 1'b0;
      c = '0; c.rf_we = 1'b1; c.rf_wsel = 2'd1; c.alub_imm = 1'b1;
      step("lw_wb", WB, c);
      exp_cnt++;

      // bne taken then not taken; alu_lt must not matter
      opcode = 5'd2;
      for (int k = 0; k < 2; k++) begin
         imem_ready = 1'b1;
         step("bne_if", IF, c_if(1'b1));
         imem_ready = 1'b0;
         step("bne_dec", DEC, '0);
         alu_ne = (k == 0);
         alu_lt = (k != 0);
         c = '0; c.rtar = 1'b1; c.aluop = 5'd1; c.pc_sel = 2'd1;
         c.pc_we = (k == 0);
         step(k == 0 ? "bne_taken" : "bne_not_taken", EXE, c);
         exp_cnt++;
         alu_ne = 1'b0; alu_lt = 1'b0;
      end

      // jal finishes in DECODE
      opcode = 5'd3; imem_ready = 1'b1;
      step("jal_if", IF, c_if(1'b1));
      imem_ready = 1'b0;
      c = '0; c.pc_we = 1'b1; c.pc_sel = 2'd2; c.rf_we = 1'b1;
      c.rf_wsel = 2'd2; c.rd_r31 = 1'b1;
      step("jal_dec", DEC, c);
      exp_cnt++;

      // illegal opcode: single-cycle pulse, no retire
      opcode = 5'd9;
      step("jal_next_if", IF, c_if(1'b0));
      imem_ready = 1'b1;
      step("ill_if", IF, c_if(1'b1));
      imem_ready = 1'b0;
      c = '0; c.illegal = 1'b1;
      step("ill_dec", DEC, c);
      step("ill_next_if", IF, c_if(1'b0));

      // ready on the 16th waiting cycle wins over the timeout (j opcode)
      opcode = 5'd1;
      for (int i = 0; i < 14; i++) step("late_if_wait", IF, c_if(1'b0));
      imem_ready = 1'b1;
      step("late_if_ready", IF, c_if(1'b1));
      imem_ready = 1'b0;
      c = '0; c.pc_we = 1'b1; c.pc_sel = 2'd2;
      step("j_dec", DEC, c);
      exp_cnt++;

      // no ready for 16 IFETCH cycles: bus error and HALT
      for (int i = 0; i < 16; i++) step("to_if_wait", IF, c_if(1'b0));
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      c = '0; c.bus_error = 1'b1;
      step("halt", HALT, c);
      step("halt_hold", HALT, c);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;

      // reset from HALT
      reset_n = 1'b0;
      exp_cnt = '0;
      step("halt_reset", IDLE, '0);
      reset_n = 1'b1;
      step("post_reset_idle", IDLE, '0);
      step("post_reset_if", IF, c_if(1'b0));

      #5;
      n_asserts++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
